// File: rtl/adder_chk_if.sv
// Vector handshake carrying one adder operand pair and its observed result
// from the adder under test into adder_result_checker.
interface adder_chk_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             in_last;

  modport master (
    output in_valid, in_a, in_b, in_sum, in_cout, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sum, in_cout, in_last,
    output in_ready
  );
endinterface

// File: rtl/adder_result_checker.sv
// Response checker for the 16-bit Brent-Kung adder: golden {cout,sum} compare
// with pass/fail statistics. Define ADDER_CHK_STOP_ON_ERR_EN to end a run on the first mismatch.
module adder_result_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32,
  parameter int ERR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  adder_chk_if.slave        in_if,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic [WIDTH-1:0]  first_a,
  output logic [WIDTH-1:0]  first_b,
  output logic [WIDTH:0]    first_exp,
  output logic [WIDTH:0]    first_got
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH:0]   s1_exp, s1_got;
  logic             mismatch;
  logic             stop;
  logic             accept;
  logic             clear;

  assign mismatch = s1_valid && (s1_exp != s1_got);

`ifdef ADDER_CHK_STOP_ON_ERR_EN
  // Statistics are cleared on start, so any mismatch seen in a run is its first one.
  assign stop = mismatch && ((state == RUN) || (state == DRAIN));
`else
  assign stop = 1'b0;
`endif

  assign in_if.in_ready = (state == RUN) && !stop;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign clear          = start && ((state == IDLE) || (state == DONE));
  assign busy           = (state == RUN) || (state == DRAIN);
  assign done           = (state == DONE);
  assign pass           = done && !err_flag;

  // NOTE: next-state is defaulted to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN: begin
        if (stop)                             state_nx = DONE;
        else if (accept && in_if.in_last)     state_nx = DRAIN;
      end
      DRAIN:   if (stop || !s1_valid) state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s1_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      s1_valid <= accept;
    end
  end

  // NOTE: stage-1 data carries no reset; s1_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a   <= in_if.in_a;
      s1_b   <= in_if.in_b;
      s1_exp <= {1'b0, in_if.in_a} + {1'b0, in_if.in_b};
      s1_got <= {in_if.in_cout, in_if.in_sum};
    end
  end

  // Stage 2: statistics land one edge after stage 1, two edges after the accept.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vec_cnt   <= '0;
      err_cnt   <= '0;
      err_flag  <= 1'b0;
      first_a   <= '0;
      first_b   <= '0;
      first_exp <= '0;
      first_got <= '0;
    end else if (s1_valid) begin
      vec_cnt <= vec_cnt + 1'b1;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (!err_flag) begin
          err_flag  <= 1'b1;
          first_a   <= s1_a;
          first_b   <= s1_b;
          first_exp <= s1_exp;
          first_got <= s1_got;
        end
      end
    end
  end

endmodule
